// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch front end: widths, reset PC, fetch FSM encoding.
package riscv_pkg;

  localparam int          XLEN             = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          INST_W           = 32;
  localparam int          PC_STEP          = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with flush; head entry is visible combinationally.
module fetch_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; flush empties the queue in one cycle.
  // NOTE: state registers use <= so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are only meaningful while counted as occupied.
  // NOTE: the storage array has no reset, so it maps onto plain flops/RAM without a reset tree.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= push_data;
  end

  assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !flush));

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller: owns the fetch PC, issues credit-limited in-order requests,
// buffers returned words for decode and drops responses made stale by redirects.
module fetch_ctrl #(
  parameter int                            XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0]               RESET_PC = riscv_pkg::RESET_PC_DEFAULT,
  parameter int                            DEPTH    = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        fetch_en,
  input  logic                        redirect_valid,
  input  logic [XLEN-1:0]             redirect_pc,
  output logic                        imem_req_valid,
  input  logic                        imem_req_ready,
  output logic [XLEN-1:0]             imem_req_addr,
  input  logic                        imem_rsp_valid,
  input  logic [riscv_pkg::INST_W-1:0] imem_rsp_data,
  output logic                        inst_valid,
  input  logic                        inst_ready,
  output logic [riscv_pkg::INST_W-1:0] inst_data,
  output logic [XLEN-1:0]             inst_pc,
  output logic [XLEN-1:0]             inst_pc_plus4
);

  import riscv_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int BW = XLEN + INST_W;

  fetch_state_t    state;
  fetch_state_t    state_next;
  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   buf_count;
  logic [CW-1:0]   tag_count;
  logic [CW-1:0]   credit;
  logic [XLEN-1:0] tag_pc;
  logic [BW-1:0]   buf_head;
  logic            tag_empty;
  logic            tag_full;
  logic            buf_empty;
  logic            buf_full;
  logic            req_fire;
  logic            drop_now;
  logic            rsp_keep;
  logic            inst_pop;

  assign credit   = CW'(DEPTH) - inflight - buf_count;
  assign req_fire = imem_req_valid && imem_req_ready;
  assign drop_now = imem_rsp_valid && (drop_cnt != '0);
  // A response landing in a redirect cycle is stale by definition.
  assign rsp_keep = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;
  assign inst_pop = inst_valid && inst_ready && !redirect_valid;

  assign imem_req_addr = fetch_pc;
  assign inst_valid    = !buf_empty;
  assign inst_data     = buf_head[INST_W-1:0];
  assign inst_pc       = buf_head[BW-1:INST_W];
  assign inst_pc_plus4 = inst_pc + XLEN'(PC_STEP);

  // Tag queue: PC of every outstanding request, popped in order by responses.
  fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag_q (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (req_fire),
    .push_data (fetch_pc),
    .pop       (imem_rsp_valid),
    .flush     (1'b0),
    .head      (tag_pc),
    .count     (tag_count),
    .empty     (tag_empty),
    .full      (tag_full)
  );

  // Output buffer: {pc, word} pairs waiting for decode; flushed on redirect.
  fetch_fifo #(.WIDTH(BW), .DEPTH(DEPTH)) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rsp_keep),
    .push_data ({tag_pc, imem_rsp_data}),
    .pop       (inst_pop),
    .flush     (redirect_valid),
    .head      (buf_head),
    .count     (buf_count),
    .empty     (buf_empty),
    .full      (buf_full)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next state and request-valid; requests need RUN, a free credit and no redirect.
  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    state_next     = state;
    imem_req_valid = 1'b0;
    case (state)
      IDLE: begin
        if (fetch_en) state_next = RUN;
      end
      RUN: begin
        if (!fetch_en) state_next = IDLE;
        imem_req_valid = (credit != '0) && !redirect_valid;
      end
      default: state_next = IDLE;
    endcase
  end

  // Fetch PC: redirect target wins, otherwise advance on each accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              fetch_pc <= RESET_PC;
    else if (redirect_valid) fetch_pc <= redirect_pc;
    else if (req_fire)       fetch_pc <= fetch_pc + XLEN'(PC_STEP);
  end

  // In-flight and drop counters. On redirect every request still outstanding after
  // this cycle belongs to the old stream, so the drop count becomes that number.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
      drop_cnt <= '0;
    end else begin
      inflight <= inflight + CW'(req_fire) - CW'(imem_rsp_valid);
      if (redirect_valid) drop_cnt <= inflight - CW'(imem_rsp_valid);
      else if (drop_now)  drop_cnt <= drop_cnt - 1'b1;
    end
  end

  assert property (@(posedge clk) disable iff (!rst_n)
    (inflight <= CW'(DEPTH)) && (drop_cnt <= CW'(DEPTH)) && (buf_count <= CW'(DEPTH)));
  assert property (@(posedge clk) disable iff (!rst_n) imem_rsp_valid |-> (inflight != '0));
  assert property (@(posedge clk) disable iff (!rst_n) imem_rsp_valid |-> !tag_empty);
  assert property (@(posedge clk) disable iff (!rst_n) inflight == tag_count);
  assert property (@(posedge clk) disable iff (!rst_n) drop_cnt <= inflight);
  assert property (@(posedge clk) disable iff (!rst_n) !(req_fire && tag_full));
  assert property (@(posedge clk) disable iff (!rst_n) !(rsp_keep && buf_full));

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: in-order memory model, address checker,
// decode-side scoreboard, a table of redirect scenarios and hand-written corner cases.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc_plus4;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          req_cnt = 0;
  int          inst_cnt = 0;
  logic        mem_stall = 1'b0;
  logic [31:0] exp_addr = 32'h0;
  logic [31:0] mem_q [$];
  logic [31:0] sb_q [$];
  logic [31:0] fire_q [$];

  always #5 clk = ~clk;

  fetch_ctrl #(.XLEN(32), .RESET_PC(32'h0), .DEPTH(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_pc_plus4  (inst_pc_plus4)
  );

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_fires(input int n, input int budget, input string name);
    int k = 0;
    while (fire_q.size() < n && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (fire_q.size() < n) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timeout, got %0d instructions expected %0d", name, fire_q.size(), n);
    end
  endtask

  task automatic do_redirect(input logic [31:0] t);
    redirect_pc    = t;
    redirect_valid = 1'b1;
    cycles(1);
    redirect_valid = 1'b0;
  endtask

  // Memory model: one response per cycle, in order, one cycle after the handshake.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      mem_q.delete();
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end else if (!mem_stall && mem_q.size() != 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word_of(mem_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
    end
  end

  // Monitor: checks request addresses, feeds memory and scoreboard, checks decode output.
  always @(negedge clk) begin
    if (!rst_n) begin
      mem_q.delete();
      sb_q.delete();
      exp_addr = 32'h0;
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        check("req_addr", imem_req_addr, exp_addr);
        exp_addr = exp_addr + 32'd4;
        mem_q.push_back(imem_req_addr);
        sb_q.push_back(imem_req_addr);
        req_cnt++;
      end
      if (inst_valid && inst_ready && !redirect_valid) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_underflow: got pc %h expected no instruction", inst_pc);
        end else begin
          logic [31:0] e;
          e = sb_q.pop_front();
          check("inst_pc", inst_pc, e);
          check("inst_data", inst_data, word_of(e));
          check("inst_pc_plus4", inst_pc_plus4, e + 32'd4);
        end
        fire_q.push_back(inst_pc);
        inst_cnt++;
      end
      if (redirect_valid) begin
        check("redirect_no_req", 32'(imem_req_valid), 32'd0);
        sb_q.delete();
        exp_addr = redirect_pc;
      end
    end
  end

  typedef struct {
    logic [31:0] target;
    int          lead;
    bit          stall_mem;
    bit          hold_ready;
    logic [31:0] exp_pc0;
    logic [31:0] exp_pc1;
  } vec_t;

  initial begin
    vec_t vecs [4];
    int   c0;

    vecs[0] = '{32'h0000_0100, 4, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_0104};
    vecs[1] = '{32'h0000_1000, 5, 1'b0, 1'b1, 32'h0000_1000, 32'h0000_1004};
    vecs[2] = '{32'hFFFF_FFF8, 3, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'hFFFF_FFFC};
    vecs[3] = '{32'h0000_002A, 3, 1'b0, 1'b0, 32'h0000_002A, 32'h0000_002E};

    rst_n          = 1'b0;
    fetch_en       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b0;
    cycles(3);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_req_addr", imem_req_addr, 32'h0);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    rst_n = 1'b1;
    cycles(2);
    check("idle_no_req", 32'(imem_req_valid), 32'd0);

    // Decode stalled from the start: exactly DEPTH requests, then valid stays low.
    fetch_en = 1'b1;
    cycles(10);
    check("stall_req_count", 32'(req_cnt), 32'd2);
    check("stall_req_valid", 32'(imem_req_valid), 32'd0);
    check("stall_head_pc", inst_pc, 32'h0);

    // Release decode: stream from 0x0 in order, with steady progress.
    fire_q.delete();
    inst_ready = 1'b1;
    wait_fires(1, 20, "first_inst");
    if (fire_q.size() >= 1) check("first_pc", fire_q[0], 32'h0);
    c0 = inst_cnt;
    cycles(30);
    check("stream_progress", 32'(inst_cnt - c0 >= 15), 32'd1);

    // Table of single-redirect scenarios.
    for (int i = 0; i < 4; i++) begin
      mem_stall  = vecs[i].stall_mem;
      inst_ready = !vecs[i].hold_ready;
      cycles(vecs[i].lead);
      if (vecs[i].stall_mem) check("pre_redirect_inflight", 32'(dut.inflight), 32'd2);
      fire_q.delete();
      do_redirect(vecs[i].target);
      mem_stall  = 1'b0;
      inst_ready = 1'b1;
      wait_fires(2, 60, "vec_fires");
      if (fire_q.size() >= 2) begin
        check("vec_pc0", fire_q[0], vecs[i].exp_pc0);
        check("vec_pc1", fire_q[1], vecs[i].exp_pc1);
      end
      cycles(4);
    end

    // Redirect in the same cycle as a response and a decode pop.
    begin
      int k = 0;
      @(posedge clk);
      #2;
      while (!(imem_rsp_valid && inst_valid) && k < 20) begin
        @(posedge clk);
        #2;
        k++;
      end
      check("t4_setup_found", 32'(imem_rsp_valid && inst_valid), 32'd1);
      fire_q.delete();
      redirect_pc    = 32'h0000_0400;
      redirect_valid = 1'b1;
      @(posedge clk);
      #2;
      redirect_valid = 1'b0;
      check("t4_buf_empty", 32'(inst_valid), 32'd0);
      wait_fires(1, 30, "t4_fire");
      if (fire_q.size() >= 1) check("t4_first_pc", fire_q[0], 32'h0000_0400);
      cycles(3);
    end

    // Back-to-back redirects with two requests outstanding.
    mem_stall = 1'b1;
    cycles(4);
    check("t5_inflight", 32'(dut.inflight), 32'd2);
    fire_q.delete();
    redirect_pc    = 32'h0000_0200;
    redirect_valid = 1'b1;
    cycles(1);
    redirect_pc    = 32'h0000_0300;
    cycles(1);
    redirect_valid = 1'b0;
    mem_stall      = 1'b0;
    wait_fires(2, 40, "t5_fires");
    if (fire_q.size() >= 2) begin
      check("t5_pc0", fire_q[0], 32'h0000_0300);
      check("t5_pc1", fire_q[1], 32'h0000_0304);
    end
    cycles(4);
    check("t5_drop_cnt", 32'(dut.drop_cnt), 32'd0);

    // Reset asserted mid-burst: outputs return to reset values at once.
    cycles(3);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("mid_rst_req_addr", imem_req_addr, 32'h0);
    check("mid_rst_inst_valid", 32'(inst_valid), 32'd0);
    cycles(2);
    fire_q.delete();
    rst_n = 1'b1;
    wait_fires(1, 20, "post_rst_fire");
    if (fire_q.size() >= 1) check("post_rst_pc", fire_q[0], 32'h0);

    // Stop fetching: outstanding work drains and nothing new issues.
    fetch_en = 1'b0;
    cycles(12);
    check("drain_sb_empty", 32'(sb_q.size()), 32'd0);
    check("drain_req_valid", 32'(imem_req_valid), 32'd0);
    check("drain_inst_valid", 32'(inst_valid), 32'd0);
    check("drain_inflight", 32'(dut.inflight), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
